// File: rtl/spi_ram_burst_pkg.sv
// Shared types and constants for the SPI RAM burst back-end.
package spi_ram_burst_pkg;

    // Frame control field carried in the two MSBs of every SPI frame.
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    // Per-direction address state; ADDR_SET is only left through reset.
    typedef enum logic {
        ADDR_UNSET = 1'b0,
        ADDR_SET   = 1'b1
    } addr_state_e;

    localparam int ERR_CNT_W = 8;

    // Payload must be wide enough for either an address or a data word.
    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_ram_burst_if.sv
// Frame/response bundle between the SPI slave (de)serialiser and the RAM back-end.
interface spi_ram_burst_if #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_WIDTH = 8
);
    import spi_ram_burst_pkg::*;

    localparam int PAYLOAD_W = max(ADDR_SIZE, MEM_WIDTH);

    logic [PAYLOAD_W+1:0]  rx_data;
    logic                  rx_valid;
    logic [MEM_WIDTH-1:0]  tx_data;
    logic                  tx_valid;
    logic                  err;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output rx_data, rx_valid,
        input  tx_data, tx_valid, err, err_cnt
    );

    modport slave (
        input  rx_data, rx_valid,
        output tx_data, tx_valid, err, err_cnt
    );

endinterface

// File: rtl/spi_ram_burst_mem.sv
// MEM_DEPTH x MEM_WIDTH storage: synchronous write, registered read.
// The array itself is never reset so contents survive rst; only the
// read register is cleared.
module spi_ram_burst_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [ADDR_SIZE-1:0] wr_addr_i,
    input  logic [MEM_WIDTH-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_SIZE-1:0] rd_addr_i,
    output logic [MEM_WIDTH-1:0] rd_data_o
);

    logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] rd_data_q;

    // Write port, no reset on the array.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register; holds the last word read until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/spi_ram_burst.sv
// SPI RAM back-end: decodes control/payload frames, keeps independent
// write and read address pointers with optional auto-increment, and
// flags rejected commands with a pulse plus a saturating counter.
module spi_ram_burst #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_WIDTH = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_burst_if.slave bus
);
    import spi_ram_burst_pkg::*;

    localparam int                   PAYLOAD_W = max(ADDR_SIZE, MEM_WIDTH);
    localparam logic [ADDR_SIZE:0]   DEPTH_V   = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    control_e              cmd;
    logic [ADDR_SIZE-1:0]  pl_addr;
    logic [MEM_WIDTH-1:0]  pl_data;
    logic                  addr_ok;

    addr_state_e           wr_state_q, wr_state_d;
    addr_state_e           rd_state_q, rd_state_d;
    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  wr_en, rd_en, reject;
    logic [MEM_WIDTH-1:0]  rd_data;

    assign cmd     = control_e'(bus.rx_data[PAYLOAD_W+1:PAYLOAD_W]);
    assign pl_addr = bus.rx_data[ADDR_SIZE-1:0];
    assign pl_data = bus.rx_data[MEM_WIDTH-1:0];
    assign addr_ok = ({1'b0, pl_addr} < DEPTH_V);

    // Pointer after a data access: wraps at the last implemented word.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (AUTO_INC == 0) begin
            return a;
        end
        if (a == LAST_ADDR) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    // State, pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= ADDR_UNSET;
            rd_state_q <= ADDR_UNSET;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Command decode, both address FSMs and error accounting.
    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        reject     = 1'b0;
        if (bus.rx_valid) begin
            unique case (cmd)
                WR_ADDR: begin
                    if (addr_ok) begin
                        wr_addr_d  = pl_addr;
                        wr_state_d = ADDR_SET;
                    end else begin
                        reject = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (wr_state_q == ADDR_SET) begin
                        wr_en     = 1'b1;
                        wr_addr_d = next_addr(wr_addr_q);
                    end else begin
                        reject = 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (addr_ok) begin
                        rd_addr_d  = pl_addr;
                        rd_state_d = ADDR_SET;
                    end else begin
                        reject = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (rd_state_q == ADDR_SET) begin
                        rd_en     = 1'b1;
                        rd_addr_d = next_addr(rd_addr_q);
                    end else begin
                        reject = 1'b1;
                    end
                end
            endcase
        end
        err_d      = reject;
        err_cnt_d  = (reject && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
        tx_valid_d = rd_en;
    end

    spi_ram_burst_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE),
        .MEM_WIDTH (MEM_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (pl_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (rd_data)
    );

    assign bus.tx_data  = rd_data;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule
